cell_rx_arbiter: RTL and testbench

Round-robin scheduler that shares the cell-forwarding engine among the NumRx Utopia ATM-layer receivers. It selects one receiver holding a complete cell, grants it exclusively until the forwarding engine signals the cell is consumed, then advances the fairness pointer. A hold watchdog forces release if the engine stalls. It sits between the per-port `utopia1_atm_rx` instances and the HEC-check/LUT-rewrite FSM.

---
 rtl/cell_rx_arbiter_pkg.sv | 17 +
 rtl/cell_rx_arbiter_if.sv | 27 ++
 rtl/cell_rx_arbiter_rr_pick.sv | 37 +++
 rtl/cell_rx_arbiter.sv | 135 +++++++++++++
 tb/tb_cell_rx_arbiter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/cell_rx_arbiter_pkg.sv
// Shared types and constants for the Utopia receive-side cell arbiter.
package cell_rx_arbiter_pkg;

  localparam int NUM_RX   = 4;
  localparam int MAX_HOLD = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } ArbStateType;

  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/cell_rx_arbiter_if.sv
// Request/grant bundle between the Utopia receivers, the forwarding engine and the arbiter.
interface cell_rx_arbiter_if
  import cell_rx_arbiter_pkg::*;
#(
  parameter int NumRx = NUM_RX
) ();

  logic [NumRx-1:0]         rx_valid;
  logic                     enable;
  logic                     cell_done;
  logic [NumRx-1:0]         grant;
  logic [$clog2(NumRx)-1:0] grant_id;
  logic                     grant_vld;
  logic                     timeout;
  logic                     busy;

  modport master (
    output rx_valid, enable, cell_done,
    input  grant, grant_id, grant_vld, timeout, busy
  );

  modport slave (
    input  rx_valid, enable, cell_done,
    output grant, grant_id, grant_vld, timeout, busy
  );

endinterface

// File: rtl/cell_rx_arbiter_rr_pick.sv
// Round-robin selector: first requesting index at or after the pointer, wrapping at N.
// Purely combinational so it can be shared with the Tx-side scheduler.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic          w_hit;
  logic [IW-1:0] w_sel;
  int            w_pos;

  // Scan candidates starting at the pointer; once a hit is found later ones are masked.
  always_comb begin
    o_onehot = {N{1'b0}};
    o_idx    = {IW{1'b0}};
    o_any    = 1'b0;
    w_hit    = 1'b0;
    w_sel    = {IW{1'b0}};
    w_pos    = 0;
    for (int k = 0; k < N; k++) begin
      w_pos           = int'(i_ptr) + k;
      w_pos           = (w_pos >= N) ? (w_pos - N) : w_pos;
      w_sel           = IW'(w_pos);
      w_hit           = i_req[w_sel] && !o_any;
      o_onehot[w_sel] = o_onehot[w_sel] | w_hit;
      o_idx           = w_hit ? w_sel : o_idx;
      o_any           = o_any | w_hit;
    end
  end

endmodule

// File: rtl/cell_rx_arbiter.sv
// Round-robin arbiter that lends the cell-forwarding engine to one Utopia receiver at a time,
// with a hold watchdog that forces release when the engine stalls.
module cell_rx_arbiter
  import cell_rx_arbiter_pkg::*;
#(
  parameter int NumRx   = NUM_RX,
  parameter int MaxHold = MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  cell_rx_arbiter_if.slave arb
);

  localparam int            IW        = (NumRx > 1) ? $clog2(NumRx) : 1;
  localparam int            CW        = hold_cnt_width(MaxHold);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MaxHold - 1);
  localparam logic [CW-1:0] HOLD_SAT  = {CW{1'b1}};

  ArbStateType      r_state;
  logic [IW-1:0]    r_ptr;
  logic [CW-1:0]    r_hold;
  logic [IW-1:0]    r_rel_id;
  logic [NumRx-1:0] r_grant;
  logic [IW-1:0]    r_grant_id;
  logic             r_grant_vld;
  logic             r_timeout;
  logic             r_busy;

  logic [NumRx-1:0] w_pick_onehot;
  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [IW-1:0]    w_next_ptr;
  logic [CW-1:0]    w_hold_inc;
  logic             w_granted_valid;
  logic             w_released_valid;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
    return (int'(id) == NumRx - 1) ? {IW{1'b0}} : (id + IW'(1'b1));
  endfunction

  rr_pick #(
    .N  (NumRx),
    .IW (IW)
  ) u_pick (
    .i_req    (arb.rx_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_next_ptr       = wrap_inc(r_grant_id);
  assign w_hold_inc       = (r_hold == HOLD_SAT) ? r_hold : (r_hold + CW'(1'b1));
  assign w_granted_valid  = arb.rx_valid[r_grant_id];
  assign w_released_valid = arb.rx_valid[r_rel_id];

  // Arbitration FSM; the fairness pointer only moves when a grant ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ptr       <= {IW{1'b0}};
      r_hold      <= {CW{1'b0}};
      r_rel_id    <= {IW{1'b0}};
      r_grant     <= {NumRx{1'b0}};
      r_grant_id  <= {IW{1'b0}};
      r_grant_vld <= 1'b0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (arb.enable && w_pick_any) begin
            r_state     <= GRANT;
            r_grant     <= w_pick_onehot;
            r_grant_id  <= w_pick_idx;
            r_grant_vld <= 1'b1;
            r_busy      <= 1'b1;
            r_hold      <= {CW{1'b0}};
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          if (arb.cell_done || (w_granted_valid && (r_hold == HOLD_LAST))) begin
            // Engine finished or watchdog expired; done wins, so no timeout on a tie.
            r_state     <= RELEASE;
            r_timeout   <= !arb.cell_done;
            r_ptr       <= w_next_ptr;
            r_rel_id    <= r_grant_id;
            r_grant     <= {NumRx{1'b0}};
            r_grant_id  <= {IW{1'b0}};
            r_grant_vld <= 1'b0;
            r_hold      <= {CW{1'b0}};
          end else if (!w_granted_valid) begin
            r_state     <= IDLE;
            r_ptr       <= w_next_ptr;
            r_grant     <= {NumRx{1'b0}};
            r_grant_id  <= {IW{1'b0}};
            r_grant_vld <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= {CW{1'b0}};
          end else begin
            r_hold <= w_hold_inc;
          end
        end
        RELEASE: begin
          // Wait out the stale cell of the released port, bounded by the same hold limit.
          if (!w_released_valid || (r_hold == HOLD_LAST)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_hold  <= {CW{1'b0}};
          end else begin
            r_hold <= w_hold_inc;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_grant     <= {NumRx{1'b0}};
          r_grant_id  <= {IW{1'b0}};
          r_grant_vld <= 1'b0;
          r_busy      <= 1'b0;
          r_hold      <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign arb.grant     = r_grant;
  assign arb.grant_id  = r_grant_id;
  assign arb.grant_vld = r_grant_vld;
  assign arb.timeout   = r_timeout;
  assign arb.busy      = r_busy;

endmodule

// File: tb/tb_cell_rx_arbiter.sv
// Directed self-checking bench for cell_rx_arbiter with four receivers and an 8-cycle hold limit.
module tb_cell_rx_arbiter;

  localparam int NRX  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   q;

  cell_rx_arbiter_if #(.NumRx(NRX)) bus ();

  cell_rx_arbiter #(
    .NumRx   (NRX),
    .MaxHold (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic vld, input logic to, input logic bsy);
    chk({tag, ".grant"},     32'(bus.grant),     32'(g));
    chk({tag, ".grant_id"},  32'(bus.grant_id),  32'(id));
    chk({tag, ".grant_vld"}, 32'(bus.grant_vld), 32'(vld));
    chk({tag, ".timeout"},   32'(bus.timeout),   32'(to));
    chk({tag, ".busy"},      32'(bus.busy),      32'(bsy));
  endtask

  initial begin
    rst           = 1'b0;
    bus.rx_valid  = 4'b1111;
    bus.enable    = 1'b1;
    bus.cell_done = 1'b0;
    repeat (3) tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    tick();
    chk_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    // Rotation 0,1,2,3,0 with done two cycles after each grant.
    for (int p = 0; p < NRX; p++) begin
      tick();
      chk_out("rot_hold", 4'b0001 << p, 2'(p), 1'b1, 1'b0, 1'b1);
      bus.cell_done = 1'b1;
      tick();
      bus.cell_done = 1'b0;
      chk_out("rot_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
      bus.rx_valid[p] = 1'b0;
      tick();
      chk_out("rot_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
      bus.rx_valid[p] = 1'b1;
      tick();
      q = (p + 1) % NRX;
      chk_out("rot_grant", 4'b0001 << q, 2'(q), 1'b1, 1'b0, 1'b1);
    end

    // Withdraw moves the pointer without timeout; then wrap from 3 to port 1.
    bus.rx_valid = 4'b0100;
    tick();
    chk_out("withdraw0", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("skip_to_2", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    bus.rx_valid = 4'b0010;
    tick();
    chk_out("withdraw2", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("wrap_pick", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    bus.cell_done = 1'b1;
    tick();
    bus.cell_done = 1'b0;
    chk_out("wrap_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    bus.rx_valid = 4'b0000;
    tick();
    chk_out("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.rx_valid = 4'b0111;
    tick();
    chk_out("ptr_after_wrap", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);

    // Watchdog: grant held exactly HOLD cycles, then a single timeout pulse.
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      chk_out("wd_hold", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1);
    end
    tick();
    chk_out("wd_expire", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_out("wd_pulse_end", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    bus.rx_valid = 4'b0000;
    tick();
    chk_out("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.rx_valid = 4'b1111;
    tick();
    chk_out("ptr_after_wd", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

    // RELEASE gives up after HOLD cycles when the port never drops valid.
    bus.cell_done = 1'b1;
    tick();
    bus.cell_done = 1'b0;
    chk_out("rel_enter", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      chk_out("rel_wait", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_out("rel_expire", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("after_rel_expire", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    // cell_done on the expiry edge: release without timeout.
    repeat (HOLD - 1) tick();
    chk_out("pre_expiry", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    bus.cell_done = 1'b1;
    tick();
    bus.cell_done = 1'b0;
    chk_out("done_at_expiry", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
    bus.rx_valid = 4'b0000;
    tick();
    chk_out("collision_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Enable gates new grants only.
    bus.enable   = 1'b0;
    bus.rx_valid = 4'b1111;
    repeat (3) begin
      tick();
      chk_out("enable_off", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    bus.enable = 1'b1;
    tick();
    chk_out("enable_on", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);

    // Reset during GRANT clears outputs and the pointer.
    rst = 1'b0;
    tick();
    chk_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_out("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
